// File: rtl/gpio_uart_tx.sv
// gpio_uart_tx
//   Consumer end of the data memory's GPIO byte port. Every CPU write to the
//   image region (mem_we & gpio_en on a rising edge) pushes the gpio byte into
//   a small circular FIFO. The FIFO head is serialised as UART 8N1 on tx.
//   Back-to-back frames have no idle gap.
//
// Optional feature (macro GPIO_UART_TX_PARITY_EN):
//   When defined, an even-parity bit is inserted between the data bits and the
//   stop bit (8E1, 11 bit times per frame). When undefined, frames are 8N1.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//   FIFO_DEPTH    FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   mem_we      data memory write enable
//   gpio[7:0]   GPIO byte from the data memory
//   gpio_en     GPIO enable from the data memory
//   clr_ovf     synchronous clear of the sticky overflow flag
//   tx          UART serial output, idle high (registered)
//   busy        high while a frame is shifted out (registered)
//   fifo_count  number of queued bytes
//   fifo_full   fifo_count == FIFO_DEPTH
//   overflow    sticky: a byte was dropped because the FIFO was full
module gpio_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          mem_we,
  input  logic [7:0]                    gpio,
  input  logic                          gpio_en,
  input  logic                          clr_ovf,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_full,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   DEPTH     = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef GPIO_UART_TX_PARITY_EN
    S_PARITY = 3'd4,
`endif
    S_STOP   = 3'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  logic w_push;
  logic w_push_ok;
  logic w_drop;
  logic w_pop;
  logic w_full;
  logic w_empty;

  // Transmitter
  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_baud;
  logic [CW-1:0] w_baud_next;
  logic [2:0]    r_bit_idx;
  logic [2:0]    w_bit_idx_next;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_next;
  logic          r_tx;
  logic          w_tx_next;
  logic          r_busy;
  logic          w_busy_next;
  logic          w_baud_last;
`ifdef GPIO_UART_TX_PARITY_EN
  logic          r_parity;
`endif

  assign w_push      = mem_we & gpio_en;
  assign w_full      = (r_count == DEPTH);
  assign w_empty     = (r_count == '0);
  // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
  assign w_push_ok   = w_push & (~w_full | w_pop);
  assign w_drop      = w_push & w_full & ~w_pop;
  assign w_baud_last = (r_baud == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= gpio;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // A drop on the same edge as a clear keeps the flag set.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
`ifdef GPIO_UART_TX_PARITY_EN
      r_parity  <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_next;
      r_baud    <= w_baud_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
      r_tx      <= w_tx_next;
      r_busy    <= w_busy_next;
`ifdef GPIO_UART_TX_PARITY_EN
      if (w_pop) r_parity <= ^w_shift_next;
`endif
    end
  end

  // Next-state logic; the FIFO head is popped into the shift register either
  // from IDLE or at the end of STOP so consecutive frames abut.
  always_comb begin
    w_state_next   = r_state;
    w_baud_next    = r_baud + 1'b1;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_pop          = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_baud_next = '0;
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shift_next = r_mem[r_rptr];
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_baud_last) begin
          w_baud_next    = '0;
          w_bit_idx_next = '0;
          w_state_next   = S_DATA;
        end
      end
      S_DATA: begin
        if (w_baud_last) begin
          w_baud_next  = '0;
          w_shift_next = {1'b0, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
`ifdef GPIO_UART_TX_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
          end
        end
      end
`ifdef GPIO_UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_baud_last) begin
          w_baud_next  = '0;
          w_state_next = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_baud_last) begin
          w_baud_next = '0;
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_shift_next = r_mem[r_rptr];
            w_state_next = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: begin
        w_baud_next  = '0;
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Output logic is decoded from the next state so tx/busy are registered
  // yet change on the same edge as the state.
  always_comb begin
    w_tx_next   = 1'b1;
    w_busy_next = 1'b1;
    case (w_state_next)
      S_IDLE:   w_busy_next = 1'b0;
      S_START:  w_tx_next   = 1'b0;
      S_DATA:   w_tx_next   = w_shift_next[0];
`ifdef GPIO_UART_TX_PARITY_EN
      S_PARITY: w_tx_next   = r_parity;
`endif
      default:  w_tx_next   = 1'b1;
    endcase
  end

  assign tx         = r_tx;
  assign busy       = r_busy;
  assign fifo_count = r_count;
  assign fifo_full  = w_full;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_gpio_uart_tx.sv
module tb_gpio_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef GPIO_UART_TX_PARITY_EN
  localparam int FBITS = 11;
`else
  localparam int FBITS = 10;
`endif
  localparam int FCYC = FBITS * CPB;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       mem_we  = 1'b0;
  logic       gpio_en = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [7:0] gpio    = 8'h00;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;
  logic       fifo_full;
  logic       overflow;

  int n_checks = 0;
  int n_errors = 0;

  gpio_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_we    (mem_we),
    .gpio      (gpio),
    .gpio_en   (gpio_en),
    .clr_ovf   (clr_ovf),
    .tx        (tx),
    .busy      (busy),
    .fifo_count(fifo_count),
    .fifo_full (fifo_full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [7:0] b);
    gpio    = b;
    mem_we  = 1'b1;
    gpio_en = 1'b1;
    tick();
    mem_we  = 1'b0;
    gpio_en = 1'b0;
  endtask

  // Serial frame expected for byte b, bit 0 = start bit.
  function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef GPIO_UART_TX_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {2'b11, b, 1'b0};
`endif
  endfunction

  // Called just after the edge that is 'skip' cycles into the frame; checks
  // every remaining cycle and returns just after the frame's final edge.
  task automatic check_frame(input logic [7:0] b, input int skip, input string tag);
    logic [10:0] pat;
    pat = frame_of(b);
    for (int k = skip; k < FCYC; k++) begin
      check($sformatf("%s_bit%0d_cyc%0d", tag, k / CPB, k % CPB), {30'd0, busy, tx}, {30'd0, 1'b1, pat[k / CPB]});
      tick();
    end
    $display("frame %s byte=%02h checked", tag, b);
  endtask

  initial begin
    logic [7:0] ovf_bytes [6];
    ovf_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    // Reset state
    #12;
    check("rst_tx",    {31'd0, tx},        32'd1);
    check("rst_busy",  {31'd0, busy},      32'd0);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_full",  {31'd0, fifo_full}, 32'd0);
    check("rst_ovf",   {31'd0, overflow},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    $display("reset state checked");

    // Single byte 0xA5
    push_one(8'hA5);
    check("single_cnt_N",  {29'd0, fifo_count}, 32'd1);
    check("single_tx_N",   {31'd0, tx},         32'd1);
    tick();
    check("single_cnt_N1", {29'd0, fifo_count}, 32'd0);
    check_frame(8'hA5, 0, "single");
    check("single_busy_end", {31'd0, busy}, 32'd0);
    check("single_tx_end",   {31'd0, tx},   32'd1);

    // Qualification: neither half of the strobe alone pushes
    gpio = 8'hFF;
    gpio_en = 1'b1;
    mem_we  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("qual_en_only_cnt", {29'd0, fifo_count}, 32'd0);
      check("qual_en_only_tx",  {31'd0, tx},         32'd1);
    end
    gpio_en = 1'b0;
    mem_we  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("qual_we_only_cnt", {29'd0, fifo_count}, 32'd0);
      check("qual_we_only_tx",  {31'd0, tx},         32'd1);
    end
    mem_we = 1'b0;
    $display("qualification checked");

    // Back-to-back frames
    gpio = 8'h01; mem_we = 1'b1; gpio_en = 1'b1;
    tick();
    gpio = 8'h02;
    tick();
    gpio = 8'h03;
    check("b2b_tx_start", {31'd0, tx},         32'd0);
    check("b2b_cnt_N1",   {29'd0, fifo_count}, 32'd1);
    tick();
    mem_we = 1'b0; gpio_en = 1'b0;
    check("b2b_cnt_N2",   {29'd0, fifo_count}, 32'd2);
    check_frame(8'h01, 1, "b2b_1");
    check_frame(8'h02, 0, "b2b_2");
    check_frame(8'h03, 0, "b2b_3");
    check("b2b_busy_end", {31'd0, busy}, 32'd0);

    // Overflow: six consecutive pushes into an idle transmitter
    mem_we = 1'b1; gpio_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      gpio = ovf_bytes[i];
      tick();
    end
    mem_we = 1'b0; gpio_en = 1'b0;
    check("ovf_cnt",  {29'd0, fifo_count}, 32'd4);
    check("ovf_full", {31'd0, fifo_full},  32'd1);
    check("ovf_set",  {31'd0, overflow},   32'd1);
    tick();
    check("ovf_sticky", {31'd0, overflow}, 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_clr",     {31'd0, overflow},   32'd0);
    check("ovf_cnt_clr", {29'd0, fifo_count}, 32'd4);
    check_frame(8'h11, 6, "ovf_1");
    check_frame(8'h22, 0, "ovf_2");
    check_frame(8'h33, 0, "ovf_3");
    check_frame(8'h44, 0, "ovf_4");
    check_frame(8'h55, 0, "ovf_5");
    check("ovf_busy_end", {31'd0, busy},       32'd0);
    check("ovf_cnt_end",  {29'd0, fifo_count}, 32'd0);
    check("ovf_full_end", {31'd0, fifo_full},  32'd0);

    // 0x07: parity bit is 1 when the parity frame is enabled
    push_one(8'h07);
    tick();
    check_frame(8'h07, 0, "b07");
    check("b07_busy_end", {31'd0, busy}, 32'd0);

    // Reset in the middle of a frame with bytes still queued
    mem_we = 1'b1; gpio_en = 1'b1;
    gpio = 8'h5A;
    tick();
    gpio = 8'h11;
    tick();
    gpio = 8'h22;
    tick();
    mem_we = 1'b0; gpio_en = 1'b0;
    // now 2 cycles into START; advance to the first data bit (bit0 of 0x5A = 0)
    for (int i = 0; i < 3; i++) tick();
    check("midrst_pre_tx",  {31'd0, tx},         32'd0);
    check("midrst_pre_cnt", {29'd0, fifo_count}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_tx",   {31'd0, tx},         32'd1);
    check("midrst_busy", {31'd0, busy},       32'd0);
    check("midrst_cnt",  {29'd0, fifo_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3 * FCYC; i++) begin
      tick();
      check("postrst_tx",  {31'd0, tx},         32'd1);
      check("postrst_cnt", {29'd0, fifo_count}, 32'd0);
    end
    $display("mid-frame reset checked");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
